// File: rtl/shift_cmd_sequencer.sv
// Command front-end for the 8-bit barrel shifter: FIFO-buffered commands, multi-pass shifts, registered result.
// Optional build macro SHIFT_STATS_EN enables the saturating completed-command counter on stat_count_out.
//
// state | meaning
// IDLE  | no command in flight, waiting for the FIFO to hold an entry
// SHIFT | one shifter pass per cycle until the remaining amount is consumed
// DONE  | result held on res_data_out until the downstream handshake
module shift_cmd_sequencer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid_in,
    output logic        cmd_ready_out,
    input  logic [7:0]  cmd_data_in,
    input  logic [3:0]  cmd_amt_in,
    input  logic        cmd_dir_in,
    output logic [7:0]  sh_a_out,
    output logic [2:0]  sh_amt_out,
    output logic        sh_sel_out,
    input  logic [7:0]  sh_y_in,
    output logic        res_valid_out,
    input  logic        res_ready_in,
    output logic [7:0]  res_data_out,
    output logic [15:0] stat_count_out
);
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [12:0]       fifo_mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty, push, pop;
    logic [12:0]       head;

    logic [7:0]        wk_data;
    logic [3:0]        wk_rem;
    logic              wk_dir;
    logic [2:0]        pass_amt;
    logic              final_pass;
    logic              shift_step, res_load, res_clear;

    // Ready depends on the registered count only, so a full FIFO never accepts during a pop.
    assign cmd_ready_out = (fifo_count != CNT_W'(DEPTH));
    assign fifo_empty    = (fifo_count == '0);
    assign push          = cmd_valid_in && cmd_ready_out;
    assign head          = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_data_in, cmd_amt_in, cmd_dir_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign pass_amt   = (wk_rem > 4'd7) ? 3'd7 : wk_rem[2:0];
    assign final_pass = (wk_rem <= 4'd7);

    assign sh_a_out   = wk_data;
    assign sh_amt_out = pass_amt;
    assign sh_sel_out = wk_dir;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = SHIFT;
            SHIFT:   if (final_pass) state_nxt = DONE;
            DONE:    if (res_ready_in) state_nxt = fifo_empty ? IDLE : SHIFT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        shift_step = 1'b0;
        res_load   = 1'b0;
        res_clear  = 1'b0;
        case (state)
            IDLE: pop = !fifo_empty;
            SHIFT: begin
                shift_step = 1'b1;
                res_load   = final_pass;
            end
            DONE: begin
                res_clear = res_ready_in;
                pop       = res_ready_in && !fifo_empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wk_data       <= '0;
            wk_rem        <= '0;
            wk_dir        <= 1'b0;
            res_valid_out <= 1'b0;
            res_data_out  <= '0;
        end else begin
            if (pop) begin
                wk_data <= head[12:5];
                wk_rem  <= head[4:1];
                wk_dir  <= head[0];
            end else if (shift_step) begin
                wk_data <= sh_y_in;
                wk_rem  <= wk_rem - {1'b0, pass_amt};
            end
            if (res_load) begin
                res_data_out  <= sh_y_in;
                res_valid_out <= 1'b1;
            end else if (res_clear) begin
                res_valid_out <= 1'b0;
            end
        end
    end

`ifdef SHIFT_STATS_EN
    logic [15:0] stat_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_count <= '0;
        end else if (res_valid_out && res_ready_in && stat_count != 16'hFFFF) begin
            stat_count <= stat_count + 16'd1;
        end
    end

    assign stat_count_out = stat_count;
`else
    assign stat_count_out = 16'h0000;
`endif

endmodule

// File: doc/shift_cmd_sequencer.md
Name: shift_cmd_sequencer

Overview:
- Command front-end that feeds the 8-bit multifunction barrel shifter.
- Accepts shift commands on a valid/ready interface and buffers them in a small FIFO.
- Drives the shifter's data, amount and direction inputs, and registers the shifter result onto a valid/ready result interface.
- Amounts above 7 are split into several shifter passes, each pass feeding its result back as the next pass's operand.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- ADDR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  system clock; all logic rises on the positive edge.
- reset  input  1  synchronous active-high reset.
- cmd_valid_in  input  1  command present.
- cmd_ready_out  output  1  FIFO can accept a command.
- cmd_data_in  input  8  operand.
- cmd_amt_in  input  4  shift amount, 0..15.
- cmd_dir_in  input  1  0 = left, 1 = right; passed to shifter sel.
- sh_a_out  output  8  to shifter a_in.
- sh_amt_out  output  3  to shifter amt_in.
- sh_sel_out  output  1  to shifter sel_in.
- sh_y_in  input  8  from shifter out_out; combinational from sh_* outputs.
- res_valid_out  output  1  result available.
- res_ready_in  input  1  downstream accepts result.
- res_data_out  output  8  result.
- stat_count_out  output  16  completed-command counter (see Optional Feature).

Behaviour:
- Clocking and reset:
  - One clock domain, clk.
  - Reset is synchronous and active-high on reset.
  - Reset clears FIFO pointers and count, FSM to IDLE, res_valid_out=0, res_data_out=0, sh_a_out=0, sh_amt_out=0, sh_sel_out=0, stat_count_out=0, all work registers=0.
  - Reset mid-command discards the in-flight command and all queued commands.
- FIFO:
  - cmd_ready_out = !full, from registered count only. No combinational dependency on pops, so a full FIFO with a simultaneous pop does not accept a push that cycle.
  - Push on cmd_valid_in && cmd_ready_out. Entry = {data, amt, dir}.
  - Pointers wrap modulo DEPTH. Simultaneous push and pop leaves count unchanged.
- Work registers: wk_data[7:0], wk_rem[3:0], wk_dir.
  - sh_a_out=wk_data, sh_sel_out=wk_dir and sh_amt_out=min(wk_rem,7) are registered/derived from the work registers.
  - These outputs hold their values outside SHIFT.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: if FIFO non-empty, pop head into work registers and go to SHIFT.
  - SHIFT: one pass per cycle.
    - wk_data <= sh_y_in; wk_rem <= wk_rem - min(wk_rem,7).
    - If wk_rem <= 7 (final pass): res_data_out <= sh_y_in, res_valid_out <= 1, go to DONE.
    - Otherwise stay in SHIFT.
    - Pass count: amt 0..7 = 1 pass; 8..14 = 2 passes; 15 = 3 passes (7,7,1).
    - amt=0 is one pass with amount 0 (data unchanged by shifter).
  - DONE: res_valid_out and res_data_out held stable until res_ready_in.
    - On handshake: res_valid_out <= 0.
    - If FIFO non-empty, pop the next command into the work registers in the same cycle and go to SHIFT; else go to IDLE.
- Latency: command accepted at edge k, popped at edge k+1, res_valid_out high after edge k+1+P, where P = number of passes.
- Throughput: with res_ready_in held high, one 1-pass command completes every 2 cycles.
- res_ready_in asserted while res_valid_out=0 has no effect.
- Only one command is in flight. The FIFO keeps accepting commands while the FSM is busy, up to DEPTH entries.

Optional Feature:
- Macro: SHIFT_STATS_EN.
- Defined:
  - stat_count_out increments by 1 on each result handshake (res_valid_out && res_ready_in).
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined:
  - Counter logic is not compiled; stat_count_out is tied to 16'h0000.
  - All other behaviour is identical.

Test Plan:
Bench connects a behavioural shifter model: logical shift, zero fill, sel 0 = left.
1. Reset, then push {0xB4, amt 3, left} with res_ready high -> res_valid_out 2 cycles after acceptance, res_data_out=0xA0. Then push {0xB4, 3, right} -> 0x16.
2. Push {0xFF, amt 9, right} -> sh_amt_out sequence 7 then 2 on consecutive cycles, intermediate 0x01, final res_data_out=0x00 after 3 cycles. Push {0x80, amt 15, right} -> passes 7,7,1, result 0x00.
3. Hold res_ready_in low and push 5 commands with DEPTH=4 -> cmd_ready_out drops after the 4th FIFO entry is written (1 in flight + 4 queued); res_data_out stays stable. Release res_ready_in -> all results arrive in order, none lost or duplicated.
4. Push {0x5A, amt 0, left} -> res_data_out=0x5A after 1 pass.
5. Assert reset for 1 cycle during the second pass of an amt=12 command with 2 commands queued -> all outputs 0 the next cycle, no further res_valid_out, cmd_ready_out=1.
6. With SHIFT_STATS_EN defined, complete 3 commands -> stat_count_out=3. Without the macro -> stat_count_out stays 0.
